// File: rtl/dcache.sv
`default_nettype none
// dcache: direct-mapped write-back, write-allocate data cache, 32-byte lines,
// one outstanding line transaction to RAM, whole-cache flush.  Rev 1.0
module dcache #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         cpu_valid_i,
  input  logic         cpu_rw_i,
  input  logic [63:0]  cpu_addr_i,
  input  logic [63:0]  cpu_wdata_i,
  input  logic         flush_i,
  output logic         cpu_ready_o,
  output logic [63:0]  cpu_rdata_o,
  output logic         cpu_error_o,
  output logic         flush_done_o,
  output logic         mem_valid_o,
  output logic         mem_rw_o,
  output logic [63:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic         mem_ready_i,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_error_i
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 64 - 5 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    COMPARE    = 4'd1,
    WB_GAP     = 4'd2,
    WRITEBACK  = 4'd3,
    FILL_GAP   = 4'd4,
    FILL       = 4'd5,
    FLUSH_SCAN = 4'd6,
    FLUSH_GAP  = 4'd7,
    FLUSH_WB   = 4'd8
  } state_t;

  state_t           state;
  logic             req_rw;
  logic [63:0]      req_addr;
  logic [63:0]      req_wdata;
  logic [IDX_W-1:0] scan_idx;

  logic             line_valid [NUM_LINES];
  logic             line_dirty [NUM_LINES];
  logic [TAG_W-1:0] line_tag   [NUM_LINES];
  logic [255:0]     line_data  [NUM_LINES];

  logic [4:0]       req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [7:0]       shamt;
  logic [255:0]     req_line;
  logic [255:0]     line_shifted;
  logic [255:0]     word_mask;
  logic [255:0]     merged_line;
  logic             hit;
  logic             crossing;
  logic             mem_fail;

  assign req_off      = req_addr[4:0];
  assign req_idx      = req_addr[5 +: IDX_W];
  assign req_tag      = req_addr[63 -: TAG_W];
  assign shamt        = {req_off, 3'b000};
  assign req_line     = line_data[req_idx];
  assign line_shifted = req_line >> shamt;
  assign word_mask    = {192'b0, 64'hFFFF_FFFF_FFFF_FFFF} << shamt;
  assign merged_line  = (req_line & ~word_mask) | ({192'b0, req_wdata} << shamt);
  assign hit          = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
  assign crossing     = req_off > 5'd24;
  // RAM address errors are only meaningful while a transaction is being offered
  assign mem_fail     = mem_valid_o && mem_error_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      req_rw       <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      scan_idx     <= '0;
      cpu_ready_o  <= 1'b0;
      cpu_rdata_o  <= '0;
      cpu_error_o  <= 1'b0;
      flush_done_o <= 1'b0;
      mem_valid_o  <= 1'b0;
      mem_rw_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        line_valid[i] <= 1'b0;
        line_dirty[i] <= 1'b0;
      end
    end else begin
      cpu_ready_o  <= 1'b0;
      cpu_error_o  <= 1'b0;
      flush_done_o <= 1'b0;
      cpu_rdata_o  <= '0;
      case (state)
        IDLE: begin
          if (flush_i) begin
            scan_idx <= '0;
            state    <= FLUSH_SCAN;
          end else if (cpu_valid_i && !cpu_ready_o) begin
            // the completion cycle still sees the old strobe; don't restart it
            req_rw    <= cpu_rw_i;
            req_addr  <= cpu_addr_i;
            req_wdata <= cpu_wdata_i;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (crossing) begin
            cpu_ready_o <= 1'b1;
            cpu_error_o <= 1'b1;
            state       <= IDLE;
          end else if (hit) begin
            cpu_ready_o <= 1'b1;
            if (req_rw) begin
              line_data[req_idx]  <= merged_line;
              line_dirty[req_idx] <= 1'b1;
            end else begin
              cpu_rdata_o <= line_shifted[63:0];
            end
            state <= IDLE;
          end else if (line_valid[req_idx] && line_dirty[req_idx]) begin
            state <= WB_GAP;
          end else begin
            state <= FILL_GAP;
          end
        end
        WB_GAP: begin
          mem_valid_o <= 1'b1;
          mem_rw_o    <= 1'b1;
          mem_addr_o  <= {line_tag[req_idx], req_idx, 5'b00000};
          mem_wdata_o <= req_line;
          state       <= WRITEBACK;
        end
        WRITEBACK: begin
          if (mem_fail) begin
            mem_valid_o <= 1'b0;
            cpu_ready_o <= 1'b1;
            cpu_error_o <= 1'b1;
            state       <= IDLE;
          end else if (mem_ready_i) begin
            mem_valid_o         <= 1'b0;
            line_dirty[req_idx] <= 1'b0;
            state               <= FILL_GAP;
          end
        end
        FILL_GAP: begin
          mem_valid_o <= 1'b1;
          mem_rw_o    <= 1'b0;
          mem_addr_o  <= {req_tag, req_idx, 5'b00000};
          state       <= FILL;
        end
        FILL: begin
          if (mem_fail) begin
            mem_valid_o <= 1'b0;
            cpu_ready_o <= 1'b1;
            cpu_error_o <= 1'b1;
            state       <= IDLE;
          end else if (mem_ready_i) begin
            mem_valid_o         <= 1'b0;
            line_data[req_idx]  <= mem_rdata_i;
            line_tag[req_idx]   <= req_tag;
            line_valid[req_idx] <= 1'b1;
            line_dirty[req_idx] <= 1'b0;
            state               <= COMPARE;
          end
        end
        FLUSH_SCAN: begin
          if (line_valid[scan_idx] && line_dirty[scan_idx]) begin
            state <= FLUSH_GAP;
          end else if (scan_idx == LAST_IDX) begin
            flush_done_o <= 1'b1;
            state        <= IDLE;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        FLUSH_GAP: begin
          mem_valid_o <= 1'b1;
          mem_rw_o    <= 1'b1;
          mem_addr_o  <= {line_tag[scan_idx], scan_idx, 5'b00000};
          mem_wdata_o <= line_data[scan_idx];
          state       <= FLUSH_WB;
        end
        FLUSH_WB: begin
          if (mem_fail || mem_ready_i) begin
            // a failed write-back leaves the line dirty and moves on
            mem_valid_o <= 1'b0;
            if (!mem_fail) begin
              line_dirty[scan_idx] <= 1'b0;
            end
            if (scan_idx == LAST_IDX) begin
              flush_done_o <= 1'b1;
              state        <= IDLE;
            end else begin
              scan_idx <= scan_idx + IDX_W'(1);
              state    <= FLUSH_SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
// tb_dcache: scoreboard bench for dcache; flat-memory reference model, RAM responder,
// directed scenarios followed by randomized traffic.  Rev 1.0
module tb_dcache;
  localparam int NUM_LINES = 8;

  logic         clk;
  logic         rst_n;
  logic         cpu_valid;
  logic         cpu_rw;
  logic [63:0]  cpu_addr;
  logic [63:0]  cpu_wdata;
  logic         flush;
  logic         cpu_ready;
  logic [63:0]  cpu_rdata;
  logic         cpu_error;
  logic         flush_done;
  logic         mem_valid;
  logic         mem_rw;
  logic [63:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_ready;
  logic [255:0] mem_rdata;
  logic         mem_error;

  dcache #(.NUM_LINES(NUM_LINES)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cpu_valid_i(cpu_valid), .cpu_rw_i(cpu_rw), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .flush_i(flush),
    .cpu_ready_o(cpu_ready), .cpu_rdata_o(cpu_rdata), .cpu_error_o(cpu_error),
    .flush_done_o(flush_done),
    .mem_valid_o(mem_valid), .mem_rw_o(mem_rw), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .mem_error_i(mem_error)
  );

  // addresses with bit 11 set are unmapped in this RAM
  assign mem_error = mem_valid & mem_addr[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic err; logic is_read; logic [63:0] data; } resp_t;
  typedef struct { logic rw; logic err; logic [63:0] addr; logic [255:0] wdata; } mtx_t;

  resp_t resp_q[$];
  mtx_t  mem_q[$];
  int    flush_pending = 0;
  int    tests = 0;
  int    fails = 0;

  logic [255:0] arch_line [logic [63:0]];
  logic [255:0] gold_ram  [logic [63:0]];
  logic [255:0] ram_line  [logic [63:0]];
  logic         m_valid [NUM_LINES];
  logic         m_dirty [NUM_LINES];
  logic [63:0]  m_tag   [NUM_LINES];

  int   ram_lat = 2;
  int   lat_cnt = 0;
  int   mem_cnt = 0;
  int   low_run = 0;
  int   last_gap = 0;
  logic prev_valid = 1'b0;

  function automatic logic [255:0] init_line(logic [63:0] la);
    logic [255:0] l;
    logic [63:0]  a;
    for (int b = 0; b < 32; b++) begin
      a = (la << 5) + 64'(b);
      l[b*8 +: 8] = 8'(a[7:0] + a[15:8] * 8'd37);
    end
    return l;
  endfunction

  function automatic logic [255:0] arch_get(logic [63:0] la);
    if (arch_line.exists(la)) return arch_line[la];
    return init_line(la);
  endfunction

  function automatic logic [255:0] ram_get(logic [63:0] la);
    if (ram_line.exists(la)) return ram_line[la];
    return init_line(la);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_wb(input int idx);
    mtx_t m;
    logic [63:0] vla;
    vla     = (m_tag[idx] << 3) | 64'(idx);
    m.rw    = 1'b1;
    m.err   = 1'b0;
    m.addr  = vla << 5;
    m.wdata = arch_get(vla);
    mem_q.push_back(m);
    gold_ram[vla] = m.wdata;
    m_dirty[idx]  = 1'b0;
  endtask

  // The CPU sees one flat byte memory; the cache state only decides RAM traffic.
  task automatic model_req(input logic rw, input logic [63:0] addr, input logic [63:0] wdata);
    int off, idx;
    logic [63:0] tag, la;
    logic [255:0] l;
    resp_t r;
    mtx_t m;
    off = int'(addr[4:0]);
    idx = int'(addr[7:5]);
    tag = addr >> 8;
    la  = addr >> 5;
    r.err = 1'b0; r.is_read = !rw; r.data = '0;
    if (off > 24) begin
      r.err = 1'b1;
      resp_q.push_back(r);
      return;
    end
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      if (m_valid[idx] && m_dirty[idx]) push_wb(idx);
      m.rw = 1'b0; m.err = addr[11]; m.addr = la << 5; m.wdata = '0;
      mem_q.push_back(m);
      if (addr[11]) begin
        r.err = 1'b1;
        resp_q.push_back(r);
        return;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    l = arch_get(la);
    if (rw) begin
      l[off*8 +: 64] = wdata;
      arch_line[la]  = l;
      m_dirty[idx]   = 1'b1;
    end else begin
      r.data = l[off*8 +: 64];
    end
    resp_q.push_back(r);
  endtask

  task automatic model_flush();
    for (int i = 0; i < NUM_LINES; i++)
      if (m_valid[i] && m_dirty[i]) push_wb(i);
    flush_pending++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    arch_line.delete();
    foreach (gold_ram[k]) arch_line[k] = gold_ram[k];
    resp_q.delete();
    mem_q.delete();
  endtask

  task automatic mem_check(input logic err);
    mtx_t e;
    mem_cnt++;
    tests++;
    if (mem_q.size() == 0) begin
      fails++;
      $display("FAIL mem_unexpected: got rw=%0b addr=%0h err=%0b, expected no transaction",
               mem_rw, mem_addr, err);
    end else begin
      e = mem_q.pop_front();
      if (e.rw !== mem_rw || e.addr !== mem_addr || e.err !== err ||
          (e.rw && !err && mem_wdata !== e.wdata)) begin
        fails++;
        $display("FAIL mem_txn: got rw=%0b addr=%0h err=%0b wdata=%h expected rw=%0b addr=%0h err=%0b wdata=%h",
                 mem_rw, mem_addr, err, mem_wdata, e.rw, e.addr, e.err, e.wdata);
      end
    end
  endtask

  // RAM responder: registered ready, held for exactly one rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (mem_valid && !prev_valid) last_gap = low_run;
      low_run    = mem_valid ? 0 : low_run + 1;
      prev_valid = mem_valid;
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_valid && rst_n) begin
        if (mem_error) begin
          mem_check(1'b1);
        end else begin
          lat_cnt++;
          if (lat_cnt >= ram_lat) begin
            lat_cnt = 0;
            mem_check(1'b0);
            if (mem_rw) ram_line[mem_addr >> 5] = mem_wdata;
            else        mem_rdata = ram_get(mem_addr >> 5);
            mem_ready = 1'b1;
          end
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // CPU-side monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (cpu_ready) begin
        tests++;
        if (resp_q.size() == 0) begin
          fails++;
          $display("FAIL cpu_unexpected: got ready err=%0b rdata=%0h expected no response",
                   cpu_error, cpu_rdata);
        end else begin
          r = resp_q.pop_front();
          if (cpu_error !== r.err || (r.is_read && !r.err && cpu_rdata !== r.data)) begin
            fails++;
            $display("FAIL cpu_resp: got err=%0b rdata=%0h expected err=%0b rdata=%0h",
                     cpu_error, cpu_rdata, r.err, r.data);
          end
        end
      end else if (cpu_error) begin
        tests++;
        fails++;
        $display("FAIL cpu_error_alone: got error=1 with ready=0 expected error=0");
      end
      if (flush_done) begin
        tests++;
        if (flush_pending == 0) begin
          fails++;
          $display("FAIL flush_unexpected: got flush_done=1 expected 0");
        end else begin
          flush_pending--;
        end
      end
    end
  end

  task automatic do_req(input logic rw, input logic [63:0] addr, input logic [63:0] wdata,
                        output int cyc, output logic [63:0] rd, output logic er);
    logic got;
    got = 1'b0;
    rd  = '0;
    er  = 1'b0;
    model_req(rw, addr, wdata);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wdata;
    cyc = 0;
    while (!got && cyc < 500) begin
      @(negedge clk);
      cyc++;
      got = cpu_ready;
    end
    rd = cpu_rdata;
    er = cpu_error;
    cpu_valid = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL req_timeout: got no ready for addr %0h expected ready within 500 cycles", addr);
      resp_q.delete();
    end
    tests++;
    if (mem_q.size() != 0) begin
      fails++;
      $display("FAIL mem_missing: got %0d expected transactions outstanding expected 0", mem_q.size());
      mem_q.delete();
    end
  endtask

  task automatic do_flush();
    int   cyc;
    logic got;
    cyc = 0;
    got = 1'b0;
    model_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      got = flush_done;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL flush_timeout: got no flush_done expected one within 2000 cycles");
      flush_pending = 0;
    end
    tests++;
    if (mem_q.size() != 0) begin
      fails++;
      $display("FAIL flush_mem_missing: got %0d writes outstanding expected 0", mem_q.size());
      mem_q.delete();
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  int           cyc;
  int           m0;
  logic [63:0]  rd;
  logic         er;
  logic [255:0] tmp;
  logic [63:0]  tag, idx, off, addr;
  logic         found;

  initial begin
    rst_n = 1'b0; cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({cpu_ready, cpu_error, flush_done, mem_valid}), 64'h0);
    check("reset_rdata", cpu_rdata, 64'h0);
    rst_n = 1'b1;

    // cold miss then hit in the same line
    m0 = mem_cnt;
    do_req(1'b0, 64'h0008, 64'h0, cyc, rd, er);
    check("cold_rdata", rd, 64'h0F0E0D0C0B0A0908);
    check("cold_memcnt", 64'(mem_cnt - m0), 64'd1);
    m0 = mem_cnt;
    do_req(1'b0, 64'h0010, 64'h0, cyc, rd, er);
    check("hit_latency", 64'(cyc), 64'd2);
    check("hit_nomem", 64'(mem_cnt - m0), 64'd0);

    // dirty eviction: write-back then fill, one idle cycle between
    do_req(1'b1, 64'h0100, 64'h1122334455667788, cyc, rd, er);
    m0 = mem_cnt;
    do_req(1'b0, 64'h0200, 64'h0, cyc, rd, er);
    check("evict_memcnt", 64'(mem_cnt - m0), 64'd2);
    tmp = ram_get(64'h8);
    check("evict_bytes", tmp[63:0], 64'h1122334455667788);
    check("evict_gap", 64'(last_gap), 64'd1);

    // word crossing the line end
    m0 = mem_cnt;
    do_req(1'b0, 64'h001D, 64'h0, cyc, rd, er);
    check("cross_err", 64'(er), 64'd1);
    check("cross_latency", 64'(cyc), 64'd2);
    check("cross_nomem", 64'(mem_cnt - m0), 64'd0);

    // RAM address error leaves the resident line intact
    m0 = mem_cnt;
    do_req(1'b0, 64'h0800, 64'h0, cyc, rd, er);
    check("memerr_err", 64'(er), 64'd1);
    check("memerr_memcnt", 64'(mem_cnt - m0), 64'd1);
    m0 = mem_cnt;
    do_req(1'b0, 64'h0200, 64'h0, cyc, rd, er);
    check("memerr_still_hit", 64'(cyc), 64'd2);
    check("memerr_nomem", 64'(mem_cnt - m0), 64'd0);

    // flush of two dirty lines, in index order
    do_req(1'b1, 64'h0040, 64'hA5A5_0000_1234_5678, cyc, rd, er);
    do_req(1'b1, 64'h00A0, 64'h0BAD_CAFE_DEAD_BEEF, cyc, rd, er);
    m0 = mem_cnt;
    do_flush();
    check("flush_memcnt", 64'(mem_cnt - m0), 64'd2);

    // reset in the middle of a fill
    ram_lat = 20;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 64'h0300; cpu_wdata = '0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = mem_valid && !mem_rw;
    end
    check("rst_fill_seen", 64'(found), 64'd1);
    rst_n = 1'b0;
    cpu_valid = 1'b0;
    @(negedge clk);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    rst_n = 1'b1;
    model_reset();
    ram_lat = 2;
    m0 = mem_cnt;
    do_req(1'b0, 64'h0300, 64'h0, cyc, rd, er);
    check("rst_remiss", 64'(mem_cnt - m0), 64'd1);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      ram_lat = int'($urandom_range(1, 4));
      if ($urandom_range(0, 99) < 6) begin
        do_flush();
      end else begin
        tag = 64'($urandom_range(0, 5));
        if ($urandom_range(0, 99) < 4) tag = 64'($urandom_range(8, 15));
        idx  = 64'($urandom_range(0, 7));
        off  = ($urandom_range(0, 99) < 10) ? 64'($urandom_range(25, 31)) : 64'($urandom_range(0, 24));
        addr = (tag << 8) | (idx << 5) | off;
        do_req(1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, cyc, rd, er);
      end
    end

    repeat (3) @(negedge clk);
    check("end_resp_q", 64'(resp_q.size()), 64'd0);
    check("end_flush_pending", 64'(flush_pending), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of direct-mapped lines (power of 2, 32-byte lines fixed).
REQ-002 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port cpu_valid_i  input  1  CPU request strobe, held until cpu_ready_o.
REQ-005 SHALL have port cpu_rw_i  input  1  1=write 8 bytes, 0=read 8 bytes.
REQ-006 SHALL have port cpu_addr_i  input  64  byte address of 8-byte little-endian word.
REQ-007 SHALL have port cpu_wdata_i  input  64  write data.
REQ-008 SHALL have port flush_i  input  1  pulse: write back every dirty line.
REQ-009 SHALL have port cpu_ready_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port cpu_rdata_o  output  64  read data, valid while cpu_ready_o=1 and cpu_error_o=0.
REQ-011 SHALL have port cpu_error_o  output  1  request failed, valid only with cpu_ready_o.
REQ-012 SHALL have port flush_done_o  output  1  one-cycle pulse when flush completes.
REQ-013 SHALL have port mem_valid_o  output  1  line transaction request to RAM.
REQ-014 SHALL have port mem_rw_o  output  1  1=line write, 0=line read.
REQ-015 SHALL have port mem_addr_o  output  64  line address, bits [4:0] always 0.
REQ-016 SHALL have port mem_wdata_o  output  256  victim line, byte 0 at bits [7:0].
REQ-017 SHALL have ports mem_ready_i  input  1, mem_rdata_i  input  256, mem_error_i  input  1  (RAM completion, fill data, combinational address error).

Function
REQ-018 SHALL decode address as offset=[4:0], index=[4+log2(NUM_LINES):5], tag=remaining upper bits; per line store valid, dirty, tag, 256-bit data.
REQ-019 SHALL use FSM states IDLE, COMPARE, WB_GAP, WRITEBACK, FILL_GAP, FILL, FLUSH_SCAN, FLUSH_GAP, FLUSH_WB.
REQ-020 SHALL, in IDLE, go to FLUSH_SCAN if flush_i=1 (priority), else latch rw/addr/wdata and go to COMPARE if cpu_valid_i=1.
REQ-021 SHALL, in COMPARE with offset>24 (word crossing line), pulse cpu_ready_o and cpu_error_o, issue no memory traffic, return to IDLE.
REQ-022 SHALL, in COMPARE on hit (valid and tag equal), pulse cpu_ready_o; read: cpu_rdata_o = line bytes offset..offset+7; write: update those 8 bytes, set dirty; return to IDLE (hit latency = 2 cycles from cpu_valid_i).
REQ-023 SHALL, in COMPARE on miss, go to WB_GAP if victim valid and dirty, else FILL_GAP (write-allocate, write-back).
REQ-024 SHALL hold mem_valid_o=0 in every *_GAP state for exactly one cycle, so a stale registered mem_ready_i is never accepted.
REQ-025 SHALL, in WRITEBACK, drive mem_valid_o=1, mem_rw_o=1, mem_addr_o={victim tag,index,5'b0}, mem_wdata_o=victim data, stable until mem_ready_i=1, then clear dirty and go to FILL_GAP.
REQ-026 SHALL, in FILL, drive mem_valid_o=1, mem_rw_o=0, mem_addr_o={req tag,index,5'b0}; on mem_ready_i=1 capture mem_rdata_i, set valid=1, dirty=0, tag, go to COMPARE (guaranteed hit).
REQ-027 SHALL, if mem_error_i=1 in any cycle with mem_valid_o=1, drop mem_valid_o next cycle, leave line state unchanged; CPU path: pulse cpu_ready_o and cpu_error_o, go to IDLE; flush path: skip line, continue scan.
REQ-028 SHALL, in FLUSH_SCAN, step index 0..NUM_LINES-1, one line per cycle; dirty valid line -> FLUSH_GAP then FLUSH_WB (same protocol as REQ-025), then resume at next index; after last index pulse flush_done_o and return to IDLE.
REQ-029 SHALL keep cpu_ready_o, cpu_error_o, flush_done_o at 0 except their defined single-cycle pulses; mem_rw_o/mem_addr_o/mem_wdata_o don't-care when mem_valid_o=0.
REQ-030 SHALL ignore cpu_valid_i and flush_i outside IDLE.

Reset
REQ-031 SHALL, when rst_n_i=0 at a rising edge, enter IDLE, clear all valid and dirty bits, drive all outputs 0 in the following cycle, abandoning any in-progress transaction (mem_valid_o=0 next cycle).
REQ-032 SHALL not require tag/data arrays to be reset.

Verification
REQ-033 Reset; read 0x0008; RAM line 0x00 returns bytes 0x00..0x1F -> one mem read at 0x0000, cpu_rdata_o=0x0F0E0D0C0B0A0908; then read 0x0010 -> hit, no mem_valid_o, ready 2 cycles later.
REQ-034 Write 0x0100 data 0x1122334455667788, then read 0x0200 (same index 0) -> mem write at 0x0100 with bytes 0..7 = 88 77 66 55 44 33 22 11, then mem read at 0x0200, one gap cycle between.
REQ-035 Read 0x001D -> cpu_ready_o=cpu_error_o=1 in COMPARE cycle, mem_valid_o never asserted.
REQ-036 Read 0x0800 with RAM raising mem_error_i -> cpu_error_o pulse, line 0 valid bit unchanged.
REQ-037 Dirty lines at index 2 and 5, flush_i pulse -> exactly two mem writes (index 2 then 5), then flush_done_o one cycle.
REQ-038 rst_n_i=0 during FILL -> mem_valid_o=0 next cycle, subsequent read of same address misses.
